// File: rtl/colour_pkg.sv
// Shared definitions for the colour-mixer command path: channel codes,
// nibble-half selects, receiver FSM states and default clock/baud settings.
package colour_pkg;

  localparam int DEF_CLK_FREQ_HZ = 10_000_000;
  localparam int DEF_BAUD_RATE   = 1200;

  localparam logic [2:0] CH_RED   = 3'd0;
  localparam logic [2:0] CH_GREEN = 3'd1;
  localparam logic [2:0] CH_BLUE  = 3'd2;
  localparam logic [2:0] CH_INT   = 3'd3;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  // Replace one nibble of cur, keeping the other nibble intact.
  function automatic logic [7:0] write_nibble(input logic [7:0] cur,
                                              input logic       half,
                                              input logic [3:0] nib);
    logic [7:0] res;
    res = cur;
    if (half == HALF_HI) res[7:4] = nib;
    else                 res[3:0] = nib;
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, baud counter, FSM and LSB-first
// shift register. byte_valid is a one-clock pulse with no back-pressure (no ready).
module uart_rx_byte
  import colour_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic             rx_meta, rx_sync;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic             cnt_clr, idx_clr, shift_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data    <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      state_q <= state_d;
      if (cnt_clr) cnt_q <= '0;
      else         cnt_q <= cnt_q + CNT_W'(1);
      if (idx_clr)       idx_q <= '0;
      else if (shift_en) idx_q <= idx_q + 3'd1;
      if (shift_en) data <= {rx_sync, data[7:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    idx_clr    = 1'b0;
    shift_en   = 1'b0;
    byte_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_sync) state_d = ST_START;
      end
      ST_START: begin
        // Mid start bit: a line that has already returned high was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_clr = 1'b1;
          idx_clr = 1'b1;
          state_d = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_clr    = 1'b1;
          byte_valid = rx_sync;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_code.sv
// UART command decoder: each received byte writes one nibble of the red,
// green, blue or intensity register that drives the colour mixer.
module uart_rx_code
  import colour_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD_RATE   = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] intensity
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  logic [7:0] rx_data;
  logic       byte_valid;
  logic       half;
  logic [2:0] chan;
  logic [3:0] nib;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_data),
    .byte_valid(byte_valid)
  );

  assign half = rx_data[7];
  assign chan = rx_data[6:4];
  assign nib  = rx_data[3:0];

  // Channel codes 4..7 are reserved and leave every register untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      intensity <= '0;
    end else if (byte_valid) begin
      case (chan)
        CH_RED:   red       <= write_nibble(red, half, nib);
        CH_GREEN: green     <= write_nibble(green, half, nib);
        CH_BLUE:  blue      <= write_nibble(blue, half, nib);
        CH_INT:   intensity <= write_nibble(intensity, half, nib);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_code.sv
// Directed bench for uart_rx_code, run at 100 kbaud on a 10 MHz clock so that
// each bit lasts 100 clocks.
module tb_uart_rx_code;

  localparam int CLK_HZ = 10_000_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] red, green, blue, intensity;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_rx_code #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .intensity(intensity)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic [7:0] i);
    check({tag, ".red"}, red, r);
    check({tag, ".green"}, green, g);
    check({tag, ".blue"}, blue, b);
    check({tag, ".int"}, intensity, i);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    idle_bits(2);
  endtask

  initial begin
    rx    = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    idle_bits(1);

    // Test 1: red, low nibble then high nibble
    send_frame(8'h0F, 1'b1);
    check("t1_low.red", red, 8'h0F);
    send_frame(8'h8F, 1'b1);
    check_all("t1", 8'hFF, 8'h00, 8'h00, 8'h00);

    // Test 2..4: remaining channels
    send_frame(8'h1A, 1'b1);
    check("t2_low.green", green, 8'h0A);
    send_frame(8'h9A, 1'b1);
    check("t2.green", green, 8'hAA);
    send_frame(8'h2F, 1'b1);
    send_frame(8'hAF, 1'b1);
    check("t3.blue", blue, 8'hFF);
    send_frame(8'h36, 1'b1);
    check("t4_low.int", intensity, 8'h06);
    send_frame(8'hB6, 1'b1);
    check_all("t4", 8'hFF, 8'hAA, 8'hFF, 8'h66);

    // High-nibble write must leave the low nibble alone
    send_frame(8'h83, 1'b1);
    check("nib_keep.red", red, 8'h3F);

    // Test 5: reserved channel, then a framing error carrying a red write
    send_frame(8'h45, 1'b1);
    check_all("t5_ch4", 8'h3F, 8'hAA, 8'hFF, 8'h66);
    send_frame(8'h03, 1'b0);
    idle_bits(12);
    check_all("t5_frame", 8'h3F, 8'hAA, 8'hFF, 8'h66);

    // Test 6: 2 us glitch, then a real frame soon after it
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check_all("t6_glitch", 8'h3F, 8'hAA, 8'hFF, 8'h66);
    send_frame(8'h05, 1'b1);
    check("t6_after.red", red, 8'h35);

    // Test 7: reset during a frame, then a clean frame shortly afterwards
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check_all("t7_in_reset", 8'h00, 8'h00, 8'h00, 8'h00);
    rx = 1'b1;
    reset = 1'b0;
    idle_bits(1);
    check_all("t7_released", 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'h97, 1'b1);
    check_all("t7_after", 8'h00, 8'h70, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
